// File: rtl/core_sched_pkg.sv
// Shared opcodes and FSM encoding for the core dispatcher.
// Imported by core_dispatcher and its testbench.
package core_sched_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SYNC = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_SYNC_WAIT
  } state_e;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO holding decoded instructions.
// Ports: push_i/data_i write, pop_i drops head_o, full_o/empty_o status.
module sched_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Push is refused while full even if a pop happens this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/core_dispatcher.sv
// Queues decoded instructions and issues them round-robin to free cores,
// honouring SYNC barriers. Ports: in_* decoder side, core_* array side,
// busy_mask/idle/err status (all registered).
module core_dispatcher
  import core_sched_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int OP_WIDTH   = 4,
  parameter int ARG_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [ARG_WIDTH-1:0] in_arg,
  output logic [CORES-1:0]     core_start,
  output logic [OP_WIDTH-1:0]  core_op,
  output logic [ARG_WIDTH-1:0] core_arg,
  input  logic [CORES-1:0]     core_done,
  output logic [CORES-1:0]     busy_mask,
  output logic                 idle,
  output logic                 err
);

  localparam int PW = $clog2(CORES);
  localparam int DW = OP_WIDTH + ARG_WIDTH;

  state_e               state_q;
  logic [CORES-1:0]     start_q;
  logic [OP_WIDTH-1:0]  op_q;
  logic [ARG_WIDTH-1:0] arg_q;
  logic [CORES-1:0]     busy_q;
  logic [CORES-1:0]     busy_d;
  logic [PW-1:0]        rr_q;
  logic [PW-1:0]        rr_d;
  logic                 err_q;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DW-1:0]        head;
  logic [OP_WIDTH-1:0]  head_op;
  logic [ARG_WIDTH-1:0] head_arg;
  logic                 head_sync;

  logic                 grant_vld;
  logic [PW-1:0]        grant_idx;
  logic [CORES-1:0]     grant_oh;
  logic [PW:0]          scan;
  logic                 dispatch;
  logic                 sync_pop;

  assign push = in_valid && !full && (in_op != OP_WIDTH'(OP_NOP));

  sched_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({in_op, in_arg}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign head_op   = head[DW-1:ARG_WIDTH];
  assign head_arg  = head[ARG_WIDTH-1:0];
  assign head_sync = (head_op == OP_WIDTH'(OP_SYNC));

  // First free core at or after rr_q, wrapping; uses registered busy.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < CORES; k++) begin
      scan = {1'b0, rr_q} + (PW+1)'(k);
      if (scan >= (PW+1)'(CORES)) begin
        scan = scan - (PW+1)'(CORES);
      end
      if (!grant_vld && !busy_q[scan[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan[PW-1:0];
      end
    end
  end

  assign grant_oh = CORES'(1) << grant_idx;

  assign dispatch = (state_q == ST_IDLE) && !empty && !head_sync && grant_vld;
  assign sync_pop = (state_q == ST_SYNC_WAIT) && (busy_q == '0);
  assign pop      = dispatch || sync_pop;

  always_comb begin
    busy_d = busy_q & ~core_done;
    rr_d   = rr_q;
    if (dispatch) begin
      busy_d = busy_d | grant_oh;
      rr_d   = (grant_idx == PW'(CORES - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      busy_q  <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= '0;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      // Completion from a core we never started is a protocol error.
      err_q   <= err_q | (|(core_done & ~busy_q));
      unique case (state_q)
        ST_IDLE: begin
          if (!empty && head_sync) begin
            state_q <= ST_SYNC_WAIT;
          end else if (dispatch) begin
            start_q <= grant_oh;
            op_q    <= head_op;
            arg_q   <= head_arg;
          end
        end
        ST_SYNC_WAIT: begin
          if (busy_q == '0) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = !full;
  assign core_start = start_q;
  assign core_op    = op_q;
  assign core_arg   = arg_q;
  assign busy_mask  = busy_q;
  assign err        = err_q;
  assign idle       = empty && (busy_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_core_dispatcher.sv
// Scoreboard bench for core_dispatcher.
// Directed vectors; a negedge monitor checks every core_start.
module tb_core_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_arg;
  logic [3:0]  core_start;
  logic [3:0]  core_op;
  logic [15:0] core_arg;
  logic [3:0]  core_done;
  logic [3:0]  busy_mask;
  logic        idle;
  logic        err;

  typedef struct {
    int          core;
    logic [3:0]  op;
    logic [15:0] arg;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   acc;

  core_dispatcher #(
    .CORES      (4),
    .OP_WIDTH   (4),
    .ARG_WIDTH  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_arg     (in_arg),
    .core_start (core_start),
    .core_op    (core_op),
    .core_arg   (core_arg),
    .core_done  (core_done),
    .busy_mask  (busy_mask),
    .idle       (idle),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] arg,
                      input bit go, input int core, output bit a);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_arg   = arg;
    a        = in_ready;
    if (a && go) begin
      e.core = core;
      e.op   = op;
      e.arg  = arg;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    in_op    = 4'h0;
    in_arg   = 16'h0;
  endtask

  task automatic pulse(input logic [3:0] m);
    core_done = m;
    tick();
    core_done = 4'h0;
  endtask

  always @(negedge clk) begin
    if (rst_n && core_start != 4'h0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", {28'h0, core_start}, 32'h0);
      end else begin
        exp_t e;
        logic [3:0] oh;
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.core;
        chk("sb_core", {28'h0, core_start}, {28'h0, oh});
        chk("sb_op", {28'h0, core_op}, {28'h0, e.op});
        chk("sb_arg", {16'h0, core_arg}, {16'h0, e.arg});
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_arg    = 16'h0;
    core_done = 4'h0;
    tick();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_start", {28'h0, core_start}, 32'h0);
    chk("rst_op", {28'h0, core_op}, 32'h0);
    chk("rst_arg", {16'h0, core_arg}, 32'h0);
    chk("rst_busy", {28'h0, busy_mask}, 32'h0);
    chk("rst_idle", {31'h0, idle}, 32'h1);
    chk("rst_err", {31'h0, err}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // back-to-back burst fills all four cores in order
    send(4'h1, 16'h0010, 1, 0, acc);
    send(4'h2, 16'h0011, 1, 1, acc);
    send(4'h3, 16'h0012, 1, 2, acc);
    send(4'h4, 16'h0013, 1, 3, acc);
    chk("burst_start2", {28'h0, core_start}, 32'h4);
    tick();
    chk("burst_start3", {28'h0, core_start}, 32'h8);
    tick();
    chk("burst_busy", {28'h0, busy_mask}, 32'hF);
    chk("burst_idle", {31'h0, idle}, 32'h0);

    // NOP is dropped: nothing queued, nothing dispatched
    send(4'h0, 16'hDEAD, 0, 0, acc);

    // queued op waits for a done, then goes one cycle later
    send(4'h5, 16'h0055, 1, 2, acc);
    tick();
    tick();
    chk("wait_nostart", {28'h0, core_start}, 32'h0);
    pulse(4'b0100);
    chk("done_edge_nostart", {28'h0, core_start}, 32'h0);
    tick();
    chk("reuse_start", {28'h0, core_start}, 32'h4);
    chk("reuse_op", {28'h0, core_op}, 32'h5);

    // SYNC barrier: op2 held until every busy core is done
    pulse(4'b1110);
    send(4'h1, 16'h0021, 1, 3, acc);
    send(4'hF, 16'h0000, 0, 0, acc);
    send(4'h2, 16'h0022, 1, 0, acc);
    tick();
    tick();
    tick();
    pulse(4'b1000);
    tick();
    tick();
    chk("sync_hold_start", {28'h0, core_start}, 32'h0);
    chk("sync_hold_busy", {28'h0, busy_mask}, 32'h1);
    chk("sync_hold_idle", {31'h0, idle}, 32'h0);
    pulse(4'b0001);
    chk("sync_d0", {28'h0, core_start}, 32'h0);
    tick();
    chk("sync_d1", {28'h0, core_start}, 32'h0);
    tick();
    chk("sync_d2_start", {28'h0, core_start}, 32'h1);
    chk("sync_d2_op", {28'h0, core_op}, 32'h2);
    pulse(4'b0001);
    tick();

    // full queue back-pressure
    send(4'h6, 16'h0030, 1, 1, acc);
    send(4'h7, 16'h0031, 1, 2, acc);
    send(4'h8, 16'h0032, 1, 3, acc);
    send(4'h9, 16'h0033, 1, 0, acc);
    tick();
    tick();
    chk("full_busy", {28'h0, busy_mask}, 32'hF);
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 1), 16'h0040 + 16'(i), 1, (i + 1) % 4, acc);
      chk("fill_acc", {31'h0, acc}, 32'h1);
    end
    chk("full_ready", {31'h0, in_ready}, 32'h0);
    send(4'hE, 16'h00EE, 0, 0, acc);
    chk("fifth_rejected", {31'h0, acc}, 32'h0);
    tick();
    pulse(4'b1111);
    for (int i = 0; i < 6; i++) tick();
    chk("drain_busy", {28'h0, busy_mask}, 32'hF);
    chk("drain_ready", {31'h0, in_ready}, 32'h1);
    pulse(4'b1111);
    tick();

    // spurious done sets sticky err
    chk("pre_err", {31'h0, err}, 32'h0);
    pulse(4'b1000);
    chk("err_set", {31'h0, err}, 32'h1);
    chk("err_busy", {28'h0, busy_mask}, 32'h0);
    tick();
    tick();
    tick();
    chk("err_sticky", {31'h0, err}, 32'h1);

    // reset mid-burst: 3 busy, SYNC + op6 queued
    send(4'h1, 16'h0050, 1, 1, acc);
    send(4'h2, 16'h0051, 1, 2, acc);
    send(4'h3, 16'h0052, 1, 3, acc);
    tick();
    tick();
    send(4'hF, 16'h0000, 0, 0, acc);
    send(4'h6, 16'h0066, 0, 0, acc);
    tick();
    tick();
    chk("pre_rst_busy", {28'h0, busy_mask}, 32'hE);
    chk("pre_rst_idle", {31'h0, idle}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {28'h0, busy_mask}, 32'h0);
    chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
    chk("mid_rst_idle", {31'h0, idle}, 32'h1);
    chk("mid_rst_err", {31'h0, err}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send(4'h7, 16'h0077, 1, 0, acc);
    tick();
    chk("post_rst_start", {28'h0, core_start}, 32'h1);
    chk("post_rst_op", {28'h0, core_op}, 32'h7);
    pulse(4'b0010);
    chk("late_done_err", {31'h0, err}, 32'h1);
    tick();
    tick();
    tick();
    chk("sb_empty", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_dispatcher.md
# core_dispatcher

Instruction scheduler between the instruction decoder and the MatrixCore array inside the core socket. It buffers decoded instructions in a small FIFO and issues each one to a free core, picking cores round-robin. It tracks per-core busy state from completion pulses and enforces SYNC barriers, so the socket can keep all cores occupied without the decoder knowing core availability.

## Interface
- CORES, 4, number of MatrixCore instances served (2..8)
- OP_WIDTH, 4, opcode width
- ARG_WIDTH, 16, operand/descriptor width forwarded to the core
- FIFO_DEPTH, 4, instruction queue depth (power of two)

- clk  in  1  system clock; one clock domain; all logic on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  queue can accept; equals !full
- in_op  in  OP_WIDTH  opcode
- in_arg  in  ARG_WIDTH  operand
- core_start  out  CORES  one-hot, single-cycle start pulse to the selected core
- core_op  out  OP_WIDTH  opcode qualified by core_start
- core_arg  out  ARG_WIDTH  operand qualified by core_start
- core_done  in  CORES  per-core single-cycle completion pulses
- busy_mask  out  CORES  registered per-core busy flags
- idle  out  1  queue empty, busy_mask zero, FSM in IDLE
- err  out  1  sticky; set when core_done arrives for a non-busy core; cleared only by reset

## Operation
- Transfer occurs when in_valid && in_ready at a rising edge. Opcode NOP (0x0) is dropped and never queued.
- The queue is FIFO. in_ready = !full. A push while full is impossible, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: the queue head is evaluated. If the head is SYNC (0xF), go to SYNC_WAIT. Otherwise, if any core is free, dispatch and pop.
  - SYNC_WAIT: hold until busy_mask == 0, then pop SYNC with no core_start and return to IDLE.
- Core select: the first free core at or after rr_ptr, scanning upward with wrap. After a grant, rr_ptr = grant+1 mod CORES.
- On dispatch: core_start[grant] = 1 for one cycle, core_op/core_arg = head, busy_mask[grant] set.
- core_done[i] clears busy_mask[i] at the same edge. A freed core is eligible from the next cycle; selection uses the registered busy_mask.
- err is set on core_done[i] while busy_mask[i] == 0. busy_mask is unaffected in that case.
- core_op/core_arg hold their last value when core_start is zero.
- Reset mid-operation: queue emptied, busy_mask = 0, rr_ptr = 0, FSM = IDLE. In-flight core work is abandoned; any late core_done after reset sets err.

## Timing
- Reset values: in_ready=1, core_start=0, core_op=0, core_arg=0, busy_mask=0, idle=1, err=0.
- Latency: an instruction accepted into an empty queue at edge N gives core_start asserted in cycle N+1, provided a core is free.
- Throughput: one dispatch per cycle while free cores exist.
- Done-to-reuse: core_done at edge N means the core can receive core_start no earlier than cycle N+1.
- SYNC with all cores already idle: popped one cycle after it reaches the head; the next instruction dispatches the following cycle.
- All outputs are registered.

## Structure
- Package core_sched_pkg holds OP_NOP=4'h0, OP_SYNC=4'hF, and the FSM state encoding (IDLE, SYNC_WAIT).
- One sub-module: sched_fifo, a parameterised synchronous FIFO with push/pop/full/empty/head and async active-low reset.
- Round-robin selector and busy tracking stay in core_dispatcher.

## Test plan
- Reset, then push ops 1,2,3,4 with args 0x10..0x13 back-to-back. Required: core_start = 0001,0010,0100,1000 in consecutive cycles, busy_mask=1111, idle=0.
- All cores busy, push op 5, then pulse core_done[2]. Required: core_start=0100 with core_op=5 exactly one cycle after the done edge.
- Push op 1, SYNC, op 2 while core 0 is busy. Required: op 2 is held until core_done has cleared every busy core, then dispatches one cycle after the SYNC pop.
- Fill the queue with 4 entries while all cores are busy. Required: in_ready=0. A 5th in_valid is not accepted, and its data must not appear later.
- Pulse core_done[3] with busy_mask=0. Required: err=1 from the next cycle, persisting until rst_n is asserted.
- Assert rst_n low mid-burst with 2 queued entries and 3 busy cores. Required: immediate busy_mask=0, in_ready=1, idle=1. After release, op 7 goes to core 0.
